// File: rtl/dds_sched_pkg.sv
// Shared widths, configuration payload and helpers for the DDS clock-enable scheduler.
package dds_sched_pkg;

  localparam int unsigned FW_W    = 32;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned CH_W    = 4;
  localparam int unsigned NCH_MAX = 16;

  // One pending configuration request: target channel, new word, phase clear.
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [FW_W-1:0] fw;
    logic            clr;
  } cfg_t;

  // True when a requested channel index exists in an nch-channel instance.
  function automatic logic ch_in_range(input logic [CH_W-1:0] ch, input int unsigned nch);
    return 32'(ch) < nch;
  endfunction

endpackage

// File: rtl/dds_cfg_port.sv
// Valid/ready configuration capture with a single pending slot and range check.
module dds_cfg_port
  import dds_sched_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_vld,
  output logic            cfg_rdy,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [FW_W-1:0] cfg_fw,
  input  logic            cfg_clr,
  output logic            cfg_err,
  output logic            apply_req,
  output cfg_t            pend,
  input  logic            apply_ack
);

  logic bad;
  logic xfer_c;

  assign xfer_c = cfg_vld & cfg_rdy;

  // Pending register: in-range requests wait for their slot, out-of-range ones are dropped next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rdy   <= 1'b0;
      cfg_err   <= 1'b0;
      apply_req <= 1'b0;
      bad       <= 1'b0;
      pend      <= '0;
    end else begin
      cfg_err <= bad;
      cfg_rdy <= !(apply_req | bad) & !xfer_c;
      bad     <= 1'b0;
      if (apply_ack) begin
        apply_req <= 1'b0;
      end
      if (xfer_c) begin
        pend      <= '{ch: cfg_ch, fw: cfg_fw, clr: cfg_clr};
        apply_req <= ch_in_range(cfg_ch, NCH);
        bad       <= !ch_in_range(cfg_ch, NCH);
      end
    end
  end

endmodule

// File: rtl/dds_clken_sched.sv
// Multi-channel fractional clock-enable generator sharing one phase adder round-robin.
module dds_clken_sched
  import dds_sched_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned U_DLY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  ch_en,
  input  logic            sync_clr,
  input  logic            cfg_vld,
  output logic            cfg_rdy,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [FW_W-1:0] cfg_fw,
  input  logic            cfg_clr,
  output logic            cfg_err,
  output logic [NCH-1:0]  enb,
  output logic [CH_W-1:0] slot
);

  // Elaboration guard on the supported channel count.
  if (NCH < 2 || NCH > NCH_MAX) begin : g_bad_nch
    $error("dds_clken_sched: NCH must be in 2..16");
  end

  // U_DLY is kept for interface compatibility only; it carries no behaviour here.
  logic unused_dly;
  assign unused_dly = ^32'(U_DLY);

  logic [ACC_W-1:0] acc [NCH];
  logic [FW_W-1:0]  fw  [NCH];

  cfg_t             pend;
  logic             apply_req;
  logic             apply_ack_c;
  logic [ACC_W-1:0] acc_sel_c;
  logic [FW_W-1:0]  fw_sel_c;
  logic             en_sel_c;
  logic [ACC_W:0]   sum_c;

  dds_cfg_port #(
    .NCH(NCH)
  ) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .cfg_vld  (cfg_vld),
    .cfg_rdy  (cfg_rdy),
    .cfg_ch   (cfg_ch),
    .cfg_fw   (cfg_fw),
    .cfg_clr  (cfg_clr),
    .cfg_err  (cfg_err),
    .apply_req(apply_req),
    .pend     (pend),
    .apply_ack(apply_ack_c)
  );

  // Select the served channel's state and run the shared adder; flag an apply in its slot.
  always_comb begin
    acc_sel_c = '0;
    fw_sel_c  = '0;
    en_sel_c  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (slot == CH_W'(k)) begin
        acc_sel_c = acc[k];
        fw_sel_c  = fw[k];
        en_sel_c  = ch_en[k];
      end
    end
    sum_c       = {1'b0, acc_sel_c} + {1'b0, fw_sel_c};
    apply_ack_c = apply_req & !sync_clr & (pend.ch == slot);
  end

  // Slot counter, accumulator/word update and carry-to-enable register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      enb  <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc[k] <= '0;
        fw[k]  <= '0;
      end
    end else if (sync_clr) begin
      // Phase alignment: words survive, phases and the slot restart.
      slot <= '0;
      enb  <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc[k] <= '0;
      end
    end else begin
      slot <= (slot == CH_W'(NCH - 1)) ? '0 : slot + CH_W'(1);
      enb  <= '0;
      for (int k = 0; k < NCH; k++) begin
        if (slot == CH_W'(k)) begin
          // The sum this cycle already used the old word; the new one takes effect next visit.
          if (apply_ack_c) begin
            fw[k] <= pend.fw;
          end
          if (apply_ack_c && pend.clr) begin
            acc[k] <= '0;
          end else if (en_sel_c) begin
            acc[k] <= sum_c[ACC_W-1:0];
            enb[k] <= sum_c[ACC_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_clken_sched.sv
// Self-checking bench for dds_clken_sched: cycle scoreboard plus per-scenario timing checks.
module tb_dds_clken_sched;

  localparam int unsigned NCH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_en = 4'hF;
  logic        sync_clr = 1'b0;
  logic        cfg_vld = 1'b0;
  logic        cfg_rdy;
  logic [3:0]  cfg_ch = 4'd0;
  logic [31:0] cfg_fw = 32'd0;
  logic        cfg_clr = 1'b0;
  logic        cfg_err;
  logic [3:0]  enb;
  logic [3:0]  slot;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dds_clken_sched #(.NCH(NCH), .U_DLY(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .sync_clr(sync_clr),
    .cfg_vld (cfg_vld),
    .cfg_rdy (cfg_rdy),
    .cfg_ch  (cfg_ch),
    .cfg_fw  (cfg_fw),
    .cfg_clr (cfg_clr),
    .cfg_err (cfg_err),
    .enb     (enb),
    .slot    (slot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [3:0] enb;
    logic [3:0] slot;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_acc [4];
  logic [31:0] m_fw  [4];
  int          m_slot = 0;
  bit          m_req = 0, m_bad = 0, m_rdy = 0, m_err = 0, m_pclr = 0;
  logic [3:0]  m_enb = 4'd0;
  logic [3:0]  m_pch = 4'd0;
  logic [31:0] m_pfw = 32'd0;

  always @(posedge clk) begin : model
    logic [32:0] s;
    bit          xfer, app, nrdy;
    logic [1:0]  k;
    exp_t        e;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_acc[i] = 32'd0;
        m_fw[i]  = 32'd0;
      end
      m_slot = 0; m_req = 0; m_bad = 0; m_rdy = 0; m_err = 0; m_enb = 4'd0;
    end else begin
      xfer  = cfg_vld && m_rdy;
      nrdy  = !(m_req || m_bad) && !xfer;
      m_err = m_bad;
      app   = m_req && !sync_clr && (m_slot == int'(m_pch));
      if (sync_clr) begin
        for (int i = 0; i < 4; i++) m_acc[i] = 32'd0;
        m_slot = 0;
        m_enb  = 4'd0;
      end else begin
        k     = 2'(m_slot);
        m_enb = 4'd0;
        s     = 33'(m_acc[k]) + 33'(m_fw[k]);
        if (app) m_fw[k] = m_pfw;
        if (app && m_pclr) m_acc[k] = 32'd0;
        else if (ch_en[k]) begin
          m_acc[k] = s[31:0];
          m_enb[k] = s[32];
        end
        m_slot = (m_slot + 1) % NCH;
      end
      if (app) m_req = 0;
      m_bad = 0;
      if (xfer) begin
        m_pch  = cfg_ch;
        m_pfw  = cfg_fw;
        m_pclr = cfg_clr;
        m_req  = (cfg_ch < NCH);
        m_bad  = !(cfg_ch < NCH);
      end
      m_rdy = nrdy;
    end
    e.enb  = m_enb;
    e.slot = 4'(m_slot);
    e.rdy  = m_rdy;
    e.err  = m_err;
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin : mon
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (enb !== e.enb) begin
        errors++;
        $display("FAIL sb_enb cyc=%0d: got %b, want %b", cyc, enb, e.enb);
      end
      checks++;
      if (slot !== e.slot) begin
        errors++;
        $display("FAIL sb_slot cyc=%0d: got %0d, want %0d", cyc, slot, e.slot);
      end
      checks++;
      if (cfg_rdy !== e.rdy) begin
        errors++;
        $display("FAIL sb_cfg_rdy cyc=%0d: got %b, want %b", cyc, cfg_rdy, e.rdy);
      end
      checks++;
      if (cfg_err !== e.err) begin
        errors++;
        $display("FAIL sb_cfg_err cyc=%0d: got %b, want %b", cyc, cfg_err, e.err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_cfg(input logic [3:0] ch, input logic [31:0] fw, input logic clr,
                          output int c, output logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (cfg_rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_rdy_wait ch=%0d: cfg_rdy=%b after %0d cycles, want 1", ch, cfg_rdy, n);
    end
    cfg_vld = 1'b1; cfg_ch = ch; cfg_fw = fw; cfg_clr = clr;
    c = cyc;
    s = slot;
    @(negedge clk);
    cfg_vld = 1'b0; cfg_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (slot !== 4'd0) begin errors++; $display("FAIL reset_slot: got %0d, want 0", slot); end
    checks++;
    if (enb !== 4'd0) begin errors++; $display("FAIL reset_enb: got %b, want 0000", enb); end
    checks++;
    if (cfg_rdy !== 1'b0) begin errors++; $display("FAIL reset_cfg_rdy: got %b, want 0", cfg_rdy); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b, want 0", cfg_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_rise: got %b, want 1", cfg_rdy); end
  endtask

  task automatic test_pow2;
    int c, a, np, others;
    logic [3:0] s;
    int t[$];
    send_cfg(4'd0, 32'h4000_0000, 1'b0, c, s);
    a = c + ((s == 4'd0) ? 4 : 4 - int'(s));
    others = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (enb[0] === 1'b1) begin
        t.push_back(cyc);
        checks++;
        if (slot !== 4'd1) begin errors++; $display("FAIL pow2_pulse_slot: got %0d, want 1", slot); end
      end
      if (enb[3:1] !== 3'b000) others++;
    end
    np = t.size();
    checks++;
    if (np != 4) begin errors++; $display("FAIL pow2_count: got %0d pulses, want 4", np); end
    for (int i = 0; i < np; i++) begin
      checks++;
      if (t[i] != a + 17 + 16 * i) begin
        errors++;
        $display("FAIL pow2_time[%0d]: got cyc %0d, want %0d", i, t[i], a + 17 + 16 * i);
      end
    end
    checks++;
    if (others != 0) begin errors++; $display("FAIL pow2_silent: got %0d cycles with other bits, want 0", others); end
  endtask

  task automatic test_two_ch;
    int c, a2, last1, last2, first2, bad1, bad2, nothot;
    logic [3:0] s;
    send_cfg(4'd1, 32'h8000_0000, 1'b1, c, s);
    send_cfg(4'd2, 32'hFFFF_FFFF, 1'b1, c, s);
    a2 = c + ((s == 4'd2) ? 4 : (s < 4'd2 ? 2 - int'(s) : 6 - int'(s)));
    last1 = -1; last2 = -1; first2 = -1; bad1 = 0; bad2 = 0; nothot = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ($countones(enb) > 1) nothot++;
      if (enb[1] === 1'b1) begin
        if (last1 >= 0 && cyc - last1 != 8) bad1++;
        last1 = cyc;
      end
      if (enb[2] === 1'b1) begin
        if (first2 < 0) first2 = cyc;
        if (last2 >= 0 && cyc - last2 != 4) bad2++;
        last2 = cyc;
      end
    end
    checks++;
    if (first2 != a2 + 9) begin errors++; $display("FAIL two_ch_first2: got cyc %0d, want %0d", first2, a2 + 9); end
    checks++;
    if (bad1 != 0 || last1 < 0) begin errors++; $display("FAIL two_ch_spacing1: got %0d bad gaps (last %0d), want 0", bad1, last1); end
    checks++;
    if (bad2 != 0) begin errors++; $display("FAIL two_ch_spacing2: got %0d bad gaps, want 0", bad2); end
    checks++;
    if (nothot != 0) begin errors++; $display("FAIL two_ch_onehot: got %0d multi-hot cycles, want 0", nothot); end
  endtask

  task automatic test_apply_slot;
    int n;
    logic [4:0] want_rdy [5];
    n = 0;
    @(negedge clk);
    while (!(slot === 4'd1 && cfg_rdy === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(slot === 4'd1 && cfg_rdy === 1'b1)) begin
      errors++;
      $display("FAIL apply_wait: slot=%0d rdy=%b, want slot 1 rdy 1", slot, cfg_rdy);
    end
    cfg_vld = 1'b1; cfg_ch = 4'd0; cfg_fw = 32'h8000_0000; cfg_clr = 1'b0;
    // rdy expected over the next five cycles: slots 2,3,0(apply),1,2
    want_rdy[0] = 5'd0; want_rdy[1] = 5'd0; want_rdy[2] = 5'd0; want_rdy[3] = 5'd0; want_rdy[4] = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_vld = 1'b0;
      checks++;
      if (cfg_rdy !== want_rdy[i][0]) begin
        errors++;
        $display("FAIL apply_rdy[%0d]: got %b, want %b", i, cfg_rdy, want_rdy[i][0]);
      end
      if (i == 2) begin
        checks++;
        if (slot !== 4'd0) begin errors++; $display("FAIL apply_slot0: got %0d, want 0", slot); end
      end
    end
  endtask

  task automatic test_phase_clear;
    int c, a, first;
    logic [3:0] s;
    send_cfg(4'd0, 32'h4000_0000, 1'b1, c, s);
    a = c + ((s == 4'd0) ? 4 : 4 - int'(s));
    first = -1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (enb[0] === 1'b1 && cyc > a && first < 0) first = cyc;
    end
    checks++;
    if (first != a + 17) begin errors++; $display("FAIL clr_next_pulse: got cyc %0d, want %0d", first, a + 17); end
  endtask

  task automatic test_range_mask;
    int c, p, nerr, ndis, first, n;
    logic [3:0] s;
    send_cfg(4'd7, 32'h1234_5678, 1'b0, c, s);
    nerr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cfg_err === 1'b1) nerr++;
    end
    checks++;
    if (nerr != 1) begin errors++; $display("FAIL range_err_count: got %0d, want 1", nerr); end
    n = 0;
    while (enb[0] !== 1'b1 && n < 24) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (enb[0] !== 1'b1) begin errors++; $display("FAIL mask_find_pulse: got none in %0d cycles, want a pulse", n); end
    p = cyc;
    ch_en = 4'hE;
    ndis = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (enb[0] === 1'b1) ndis++;
    end
    ch_en = 4'hF;
    checks++;
    if (ndis != 0) begin errors++; $display("FAIL mask_disabled: got %0d pulses, want 0", ndis); end
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (enb[0] === 1'b1 && first < 0) first = cyc;
    end
    checks++;
    if (first != p + 48) begin errors++; $display("FAIL mask_resume: got cyc %0d, want %0d", first, p + 48); end
  endtask

  task automatic test_sync_and_reset;
    int d, first, n, c, cnt;
    logic [3:0] s;
    n = 0;
    @(negedge clk);
    while (cfg_rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    sync_clr = 1'b1;
    cfg_vld = 1'b1; cfg_ch = 4'd1; cfg_fw = 32'h2000_0000; cfg_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_vld = 1'b0;
      checks++;
      if (slot !== 4'd0 || enb !== 4'd0 || cfg_rdy !== 1'b0) begin
        errors++;
        $display("FAIL sync_hold[%0d]: slot=%0d enb=%b rdy=%b, want 0 0000 0", i, slot, enb, cfg_rdy);
      end
    end
    sync_clr = 1'b0;
    d = cyc;
    first = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (enb[0] === 1'b1 && first < 0) first = cyc;
      if (cyc == d + 2) begin
        checks++;
        if (cfg_rdy !== 1'b0) begin errors++; $display("FAIL sync_rdy_low: got %b, want 0", cfg_rdy); end
      end
      if (cyc == d + 3) begin
        checks++;
        if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL sync_rdy_rise: got %b, want 1", cfg_rdy); end
      end
    end
    checks++;
    if (first != d + 13) begin errors++; $display("FAIL sync_first_pulse: got cyc %0d, want %0d", first, d + 13); end

    // reset while a request is pending
    send_cfg(4'd3, 32'hC000_0000, 1'b0, c, s);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cfg_rdy !== 1'b0 || slot !== 4'd0 || enb !== 4'd0 || cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid[%0d]: rdy=%b slot=%0d enb=%b err=%b, want 0 0 0000 0", i, cfg_rdy, slot, enb, cfg_err);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy: got %b, want 1", cfg_rdy); end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (enb !== 4'd0) cnt++;
    end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL rst_mid_silent: got %0d pulse cycles, want 0", cnt); end
  endtask

  initial begin
    test_reset();
    test_pow2();
    test_two_ch();
    test_apply_slot();
    test_phase_clear();
    test_range_mask();
    test_sync_and_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
